instr_packer: RTL and testbench
===============================

# instr_packer

Inverse of the immediate generator: packs an immediate value plus register/function fields into a 32-bit RV32I instruction word. Two-stage valid/ready pipeline with an instruction-memory write-address counter. Used by the boot/program loader and the self-test sequencer to build instruction streams in hardware. For every in-range immediate, the immediate generator applied to the packed word returns the original immediate.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first emitted word
- `DEPTH`, 1024, number of word slots; power of two, ≥ 2
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  clears address index and `err_sticky`; pipeline contents unaffected
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid & in_ready`
- `imm_sel`  in  `imm_sel_e`  format: IMM_I/S/B/U/J; any other value means R-type
- `imm`  in  32  immediate value (byte offset for B/J)
- `opcode`  in  7  opcode field
- `rd`, `rs1`, `rs2`  in  5 each  register fields
- `funct3`  in  3  funct3 field
- `funct7`  in  7  funct7 field (R-type only)
- `out_valid`  out  1  packed word valid
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `out_instr`  out  32  packed instruction
- `out_addr`  out  32  BASE_ADDR + 4*index for this word
- `out_err`  out  1  immediate out of range for this word
- `err_sticky`  out  1  set by any accepted out-of-range request
- `count`  out  $clog2(DEPTH)+1  words emitted since reset/clr, saturating

## Operation
- Packing, with i = imm:
  - I: {i[11:0], rs1, funct3, rd, opcode}
  - S: {i[11:5], rs2, rs1, funct3, i[4:0], opcode}
  - B: {i[12], i[10:5], rs2, rs1, funct3, i[4:1], i[11], opcode}
  - U: {i[31:12], rd, opcode}
  - J: {i[20], i[10:1], i[11], i[19:12], rd, opcode}
  - R/other: {funct7, rs2, rs1, funct3, rd, opcode}
- Range rules (error when violated):
  - I/S: i[31:11] all equal.
  - B: i[31:12] all equal and i[0]=0.
  - J: i[31:20] all equal and i[0]=0.
  - U: i[11:0]=0.
  - R: never an error.
- On error the word is still emitted, packed from truncated bits, with `out_err`=1.
- Stage 1 registers the inputs and computes the range error. Stage 2 holds the packed word, error flag and address.
- Index: increments on each output handshake, wraps DEPTH-1→0. `out_addr` is taken from the index when the word enters stage 2.
- `count` increments on each output handshake and saturates at DEPTH.

## Timing
- Reset values: `in_ready`=1; `out_valid`=0; `out_instr`=0; `out_addr`=BASE_ADDR; `out_err`=0; `err_sticky`=0; `count`=0; index=0.
- Latency: accept at cycle N → `out_valid` at N+2 when not stalled.
- Throughput: 1 word/cycle.
- A stage advances when the next stage is empty or being drained in the same cycle.
- `in_ready` = !s1_valid | s1_advance, so it is combinational from `out_ready`.
- Stalled output: `out_instr`, `out_addr` and `out_err` hold stable while `out_valid & !out_ready`. At most 2 words are buffered, then `in_ready`=0.
- `clr` together with an output handshake: index becomes 0, not 1, and `count` becomes 0.
- `clr` together with an accepted error request: `err_sticky` ends at 1 (the set wins).
- `rst` mid-operation flushes both stages. In-flight words are dropped and no handshake completes that cycle.

## Configuration
- `INSTR_PACKER_RANGE_CHECK_EN` defined: range rules as above; `out_err` and `err_sticky` are live.
- Not defined: no range logic. `out_err` and `err_sticky` are tied to 0. Packing and timing are unchanged.

## Test plan
- I, imm=32'hFFFF_FFFF, opcode=7'h13, rd=1, rs1=0, funct3=0 -> `out_instr`=32'hFFF0_0093, `out_err`=0, `out_addr`=BASE_ADDR, 2 cycles after accept.
- B, imm=32'hFFFF_FFFC, opcode=7'h63, rs1=rs2=0 -> 32'hFE00_0EE3. J, imm=8, rd=1, opcode=7'h6F -> 32'h0080_00EF. Feeding each word back through the immediate generator returns the original imm.
- I, imm=2048 -> `out_err`=1, `err_sticky`=1 and stays set. U, imm=32'h0000_1001 -> `out_err`=1. With the macro undefined, both cases give `out_err`=0.
- `out_ready`=0 for 5 cycles while 3 back-to-back requests are offered -> 2 accepted, `in_ready`=0, third held. After release, all 3 emerge in order at BASE, +4, +8.
- DEPTH=4, 5 transfers -> `out_addr` 0,4,8,12,0; `count` saturates at 4. `clr` coincident with a handshake -> next `out_addr`=BASE_ADDR.
- `rst` asserted with both stages full -> next cycle `out_valid`=0, `in_ready`=1, `count`=0.

Source files
------------

// File: rtl/instr_packer.sv
// -----------------------------------------------------------------------------
// instr_packer
//
// Packs an immediate plus register/function fields into a 32-bit RV32I
// instruction word. This is the inverse of the immediate generator: for any
// in-range immediate, decoding the packed word returns the original value.
// Two-stage valid/ready pipeline. Each emitted word is tagged with an
// instruction-memory write address taken from a wrapping word index.
//
// Optional feature macro: INSTR_PACKER_RANGE_CHECK_EN
//   defined     -> immediate range checking drives out_err / err_sticky
//   not defined -> no range logic, out_err and err_sticky are constant 0
//
// Parameters
//   BASE_ADDR  byte address of the first emitted word
//   DEPTH      number of word slots (power of two, >= 2)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clr               clears address index, count and err_sticky
//   in_valid/ready    request handshake
//   imm_sel           immediate format (IMM_I/S/B/U/J, anything else = R-type)
//   imm               immediate value (byte offset for B/J)
//   opcode, rd, rs1, rs2, funct3, funct7   instruction fields
//   out_valid/ready   packed word handshake
//   out_instr         packed instruction word
//   out_addr          BASE_ADDR + 4*index for this word
//   out_err           immediate was out of range for this word
//   err_sticky        set by any accepted out-of-range request
//   count             words emitted since reset/clr, saturating at DEPTH
// -----------------------------------------------------------------------------
package instr_packer_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd7
  } imm_sel_e;
endpackage

module instr_packer
  import instr_packer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  imm_sel_e                   imm_sel,
  input  logic [31:0]                imm,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic                       out_err,
  output logic                       err_sticky,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              IW      = $clog2(DEPTH);
  localparam int              CW      = IW + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);

  // Field packing for each immediate format; truncates silently, the range
  // check is a separate concern.
  function automatic logic [31:0] pack_word(
    input imm_sel_e    sel,
    input logic [31:0] i,
    input logic [6:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7
  );
    case (sel)
      IMM_I:   pack_word = {i[11:0], f_rs1, f3, f_rd, op};
      IMM_S:   pack_word = {i[11:5], f_rs2, f_rs1, f3, i[4:0], op};
      IMM_B:   pack_word = {i[12], i[10:5], f_rs2, f_rs1, f3, i[4:1], i[11], op};
      IMM_U:   pack_word = {i[31:12], f_rd, op};
      IMM_J:   pack_word = {i[20], i[10:1], i[11], i[19:12], f_rd, op};
      default: pack_word = {f7, f_rs2, f_rs1, f3, f_rd, op};
    endcase
  endfunction

`ifdef INSTR_PACKER_RANGE_CHECK_EN
  // An immediate is representable when every bit above the encoded sign bit
  // matches it; B/J offsets must additionally be even, U must have a zero
  // low 12 bits.
  function automatic logic range_bad(input imm_sel_e sel, input logic [31:0] i);
    case (sel)
      IMM_I, IMM_S: range_bad = !((&i[31:11]) || !(|i[31:11]));
      IMM_B:        range_bad = !((&i[31:12]) || !(|i[31:12])) || i[0];
      IMM_J:        range_bad = !((&i[31:20]) || !(|i[31:20])) || i[0];
      IMM_U:        range_bad = |i[11:0];
      default:      range_bad = 1'b0;
    endcase
  endfunction
`endif

  logic range_err;
`ifdef INSTR_PACKER_RANGE_CHECK_EN
  assign range_err = range_bad(imm_sel, imm);
`else
  assign range_err = 1'b0;
`endif

  // stage 1 registers
  logic        vld_p1;
  imm_sel_e    sel_p1;
  logic [31:0] imm_p1;
  logic [6:0]  opcode_p1;
  logic [4:0]  rd_p1;
  logic [4:0]  rs1_p1;
  logic [4:0]  rs2_p1;
  logic [2:0]  funct3_p1;
  logic [6:0]  funct7_p1;
  logic        err_p1;

  // stage 2 registers
  logic        vld_p2;
  logic [31:0] instr_p2;
  logic [31:0] addr_p2;
  logic        err_p2;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] cnt_q;
  logic          sticky_q;

  logic in_hs;
  logic out_hs;
  logic s1_advance;

  assign out_hs     = vld_p2 & out_ready;
  assign s1_advance = vld_p1 & (!vld_p2 | out_ready);
  assign in_ready   = !vld_p1 | s1_advance;
  assign in_hs      = in_valid & in_ready;

  // The address for a word entering stage 2 must reflect a handshake of the
  // previous word in the same cycle, so it is taken from the next index.
  always_comb begin
    idx_nxt = idx_q;
    if (clr)
      idx_nxt = '0;
    else if (out_hs)
      idx_nxt = idx_q + {{(IW-1){1'b0}}, 1'b1};
  end

  // ---- stage 1: capture request, evaluate range ----
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (in_hs)
      vld_p1 <= 1'b1;
    else if (s1_advance)
      vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      sel_p1    <= imm_sel;
      imm_p1    <= imm;
      opcode_p1 <= opcode;
      rd_p1     <= rd;
      rs1_p1    <= rs1;
      rs2_p1    <= rs2;
      funct3_p1 <= funct3;
      funct7_p1 <= funct7;
      err_p1    <= range_err;
    end
  end

  // ---- stage 2: packed word, error flag, address ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      addr_p2  <= BASE_ADDR;
      err_p2   <= 1'b0;
    end else if (s1_advance) begin
      vld_p2   <= 1'b1;
      instr_p2 <= pack_word(sel_p1, imm_p1, opcode_p1, rd_p1, rs1_p1, rs2_p1,
                            funct3_p1, funct7_p1);
      addr_p2  <= BASE_ADDR + {{(30-IW){1'b0}}, idx_nxt, 2'b00};
      err_p2   <= err_p1;
    end else if (out_hs) begin
      vld_p2   <= 1'b0;
    end
  end

  // ---- output side bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_nxt;
      if (clr)
        cnt_q <= '0;
      else if (out_hs && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // A new error in the same cycle as clr wins, so it is never lost.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_q <= 1'b0;
    else if (in_hs && range_err)
      sticky_q <= 1'b1;
    else if (clr)
      sticky_q <= 1'b0;
  end

  assign out_valid  = vld_p2;
  assign out_instr  = instr_p2;
  assign out_addr   = addr_p2;
  assign out_err    = err_p2;
  assign err_sticky = sticky_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_instr_packer.sv
// -----------------------------------------------------------------------------
// tb_instr_packer
//
// Directed bench for instr_packer (BASE_ADDR=0x1000, DEPTH=4). A table of
// single-word vectors with hand-computed words is pushed through one at a
// time, followed by sequences for stall/backpressure, clr interactions and a
// mid-operation reset. In-range immediates are also decoded back with an
// immediate-generator model and compared against the original value.
// -----------------------------------------------------------------------------
module tb_instr_packer;
  import instr_packer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DEP  = 4;
`ifdef INSTR_PACKER_RANGE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready;
  imm_sel_e    imm_sel;
  logic [31:0] imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] out_instr, out_addr;
  logic        out_err, err_sticky;
  logic [2:0]  count;

  instr_packer #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    imm_sel_e    sel;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_instr;
    logic        exp_err;
    logic        rt;
  } vec_t;

  vec_t        tv[12];
  vec_t        sv[3];
  logic [31:0] sexp[3];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    imm_sel = v.sel;
    imm     = v.imm;
    opcode  = v.op;
    rd      = v.rd;
    rs1     = v.rs1;
    rs2     = v.rs2;
    funct3  = v.f3;
    funct7  = v.f7;
  endtask

  // Immediate generator: recovers the sign-extended immediate from a word.
  function automatic logic [31:0] imm_gen(input imm_sel_e sel, input logic [31:0] w);
    case (sel)
      IMM_I:   imm_gen = {{20{w[31]}}, w[31:20]};
      IMM_S:   imm_gen = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm_gen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm_gen = {w[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_gen = 32'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
    logic        exp_sticky;
    logic        hs_in;
    int          sent;
    int          got;

    tv[0]  = '{IMM_I, 32'hFFFF_FFFF, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0093, 1'b0, 1'b1};
    tv[1]  = '{IMM_B, 32'hFFFF_FFFC, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFE00_0EE3, 1'b0, 1'b1};
    tv[2]  = '{IMM_J, 32'h0000_0008, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0080_00EF, 1'b0, 1'b1};
    tv[3]  = '{IMM_I, 32'h0000_0800, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0093, 1'b1, 1'b0};
    tv[4]  = '{IMM_U, 32'h0000_1001, 7'h37, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_12B7, 1'b1, 1'b0};
    tv[5]  = '{IMM_S, 32'hFFFF_FFFC, 7'h23, 5'd0,  5'd3, 5'd2, 3'd2, 7'h00, 32'hFE21_AE23, 1'b0, 1'b1};
    tv[6]  = '{IMM_R, 32'h0000_0000, 7'h33, 5'd1,  5'd2, 5'd3, 3'd0, 7'h20, 32'h4031_00B3, 1'b0, 1'b0};
    tv[7]  = '{IMM_U, 32'hDEAD_B000, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hDEAD_B537, 1'b0, 1'b1};
    tv[8]  = '{IMM_J, 32'h0000_0003, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0020_006F, 1'b1, 1'b0};
    tv[9]  = '{IMM_B, 32'h0000_1000, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0063, 1'b1, 1'b0};
    tv[10] = '{IMM_I, 32'hFFFF_F800, 7'h13, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_0013, 1'b0, 1'b1};
    tv[11] = '{IMM_J, 32'hFFF0_0000, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h8000_006F, 1'b0, 1'b1};

    sv[0] = '{IMM_I, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0093, 1'b0, 1'b1};
    sv[1] = '{IMM_I, 32'd2, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0020_0113, 1'b0, 1'b1};
    sv[2] = '{IMM_I, 32'd3, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0030_0193, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) sexp[k] = sv[k].exp_instr;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(tv[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_instr",  out_instr,       32'd0);
    chk("rst_out_addr",   out_addr,        BASE);
    chk("rst_out_err",    32'(out_err),    32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_count",      32'(count),      32'd0);

    // Table: one word at a time, output always ready
    exp_sticky = 1'b0;
    exp_cnt    = 0;
    for (int k = 0; k < 12; k++) begin
      set_req(tv[k]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (tv[k].exp_err && CHK) exp_sticky = 1'b1;
      chk("tbl_lat1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      exp_addr = BASE + 32'(4 * (k % DEP));
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_instr", out_instr, tv[k].exp_instr);
      chk("tbl_err", 32'(out_err), 32'(tv[k].exp_err & CHK));
      chk("tbl_addr", out_addr, exp_addr);
      chk("tbl_sticky", 32'(err_sticky), 32'(exp_sticky));
      if (tv[k].rt) chk("tbl_roundtrip", imm_gen(tv[k].sel, out_instr), tv[k].imm);
      @(negedge clk);
      if (exp_cnt < DEP) exp_cnt = exp_cnt + 1;
      chk("tbl_count", 32'(count), exp_cnt);
      chk("tbl_drained", 32'(out_valid), 32'd0);
    end

    // clr alone
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);

    // Backpressure: 3 requests offered while output stalled for 5 cycles
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      if (sent < 3) begin set_req(sv[sent]); in_valid = 1'b1; end
      #1 hs_in = in_ready;
      if (c >= 2) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold_instr", out_instr, sexp[0]);
        chk("stall_hold_addr", out_addr, BASE);
      end
      @(negedge clk);
      if (hs_in) sent++;
    end
    chk("stall_accepted", 32'(sent), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      #1 hs_in = in_valid & in_ready;
      if (out_valid) begin
        chk("drain_instr", out_instr, sexp[got]);
        chk("drain_addr", out_addr, BASE + 32'(4 * got));
        got++;
      end
      @(negedge clk);
      if (hs_in) begin
        sent++;
        if (sent < 3) set_req(sv[sent]);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("drain_words", 32'(got), 32'd3);
    chk("drain_count", 32'(count), 32'd3);

    // clr coincident with an output handshake
    set_req(sv[0]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrhs_valid", 32'(out_valid), 32'd1);
    chk("clrhs_addr", out_addr, BASE + 32'd12);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrhs_count", 32'(count), 32'd0);
    chk("clrhs_drained", 32'(out_valid), 32'd0);
    set_req(sv[1]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrhs_next_addr", out_addr, BASE);
    chk("clrhs_next_instr", out_instr, sexp[1]);
    @(negedge clk);
    chk("clrhs_next_count", 32'(count), 32'd1);

    // clr together with an accepted out-of-range request
    set_req(tv[3]); in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    chk("clrerr_sticky", 32'(err_sticky), 32'(CHK));
    @(negedge clk);
    chk("clrerr_out_err", 32'(out_err), 32'(CHK));
    chk("clrerr_addr", out_addr, BASE);
    @(negedge clk);
    chk("clrerr_count", 32'(count), 32'd1);

    // Reset with both stages full
    out_ready = 1'b0;
    set_req(sv[0]); in_valid = 1'b1;
    @(negedge clk);
    set_req(sv[1]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    chk("midrst_addr", out_addr, BASE);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    set_req(sv[2]); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 32'd1);
    chk("postrst_instr", out_instr, sexp[2]);
    chk("postrst_addr", out_addr, BASE);
    @(negedge clk);
    chk("postrst_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
